// File: rtl/ex_mem_stage.sv
// -----------------------------------------------------------------------------
// ex_mem_stage
//
// EX/MEM pipeline register of the RISC-V core. It sits directly after the ALU.
// It registers the ALU result, store data, destination register and the
// memory/writeback control of one instruction. It also resolves conditional
// branches from the ALU zero flag and flags illegal memory accesses.
// Instructions are handed to the MEM stage over a valid/stall handshake.
//
// Parameters
//   size   datapath width of ALU result, store data and PCs (must be >= 2)
//   RD_W   destination register index width
//
// Ports
//   clk, rst            single rising-edge clock, synchronous active-high reset
//   flush               kill the instruction offered this cycle and drop the
//                       instruction held for MEM
//   ex_valid/ex_ready   upstream handshake; ex_ready = !mem_valid || !mem_stall
//   alu_out, alu_zero   ALU result (load/store address) and zero flag
//   ex_rd, ex_reg_write destination register and writeback enable
//   ex_mem_read/_write  load / store request
//   ex_store_data       store data (rs2)
//   ex_branch(_ne)      conditional branch, 1 = BNE, 0 = BEQ
//   ex_branch_target    branch target PC
//   mem_stall           MEM stage cannot accept
//   mem_*               registered instruction for MEM; the enables are gated
//   redirect_valid/_pc  one-cycle taken-branch pulse and its target
//   misaligned          one-cycle pulse: word load/store with alu_out[1:0] != 0
//   ctrl_err            sticky: load and store requested together
//
// Optional feature (macro EX_MEM_BRANCH_STATS_EN)
//   Adds br_total / br_taken. These are 32-bit wrapping counters of captured
//   branches and of taken branches. Without the macro the ports do not exist.
// -----------------------------------------------------------------------------
module ex_mem_stage #(
   parameter int size = 32,
   parameter int RD_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   // upstream handshake
   input  logic            ex_valid,
   output logic            ex_ready,
   // EX-stage instruction
   input  logic [size-1:0] alu_out,
   input  logic            alu_zero,
   input  logic [RD_W-1:0] ex_rd,
   input  logic            ex_reg_write,
   input  logic            ex_mem_read,
   input  logic            ex_mem_write,
   input  logic [size-1:0] ex_store_data,
   input  logic            ex_branch,
   input  logic            ex_branch_ne,
   input  logic [size-1:0] ex_branch_target,
   // downstream handshake and MEM-stage instruction
   input  logic            mem_stall,
   output logic            mem_valid,
   output logic [size-1:0] mem_alu_out,
   output logic [RD_W-1:0] mem_rd,
   output logic            mem_reg_write,
   output logic            mem_mem_read,
   output logic            mem_mem_write,
   output logic [size-1:0] mem_store_data,
   // branch redirect and status
   output logic            redirect_valid,
   output logic [size-1:0] redirect_pc,
   output logic            misaligned,
   output logic            ctrl_err
`ifdef EX_MEM_BRANCH_STATS_EN
   ,
   output logic [31:0]     br_total,
   output logic [31:0]     br_taken
`endif
);

   // --------------------------------------------------------------------------
   // Handshake and instruction decode
   // --------------------------------------------------------------------------
   logic            w_ex_ready;
   logic            w_accept;          // ready and not flushed
   logic            w_capture;         // a valid instruction is latched
   logic            w_is_mem_access;
   logic            w_addr_misaligned;
   logic            w_rw_conflict;
   logic            w_branch_taken;
   logic            w_reg_write_gated;
   logic            w_mem_read_gated;
   logic            w_mem_write_gated;

   // Output-facing registers
   logic            r_mem_valid;
   logic [size-1:0] r_mem_alu_out;
   logic [RD_W-1:0] r_mem_rd;
   logic            r_mem_reg_write;
   logic            r_mem_mem_read;
   logic            r_mem_mem_write;
   logic [size-1:0] r_mem_store_data;
   logic            r_redirect_valid;
   logic [size-1:0] r_redirect_pc;
   logic            r_misaligned;
   logic            r_ctrl_err;

   // The stage can take a new instruction when it is empty, or when MEM drains
   // it this cycle. ex_valid is deliberately not part of this term.
   assign w_ex_ready = !r_mem_valid || !mem_stall;
   assign w_accept   = w_ex_ready && !flush;
   assign w_capture  = w_accept && ex_valid;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so that no path
      // leaves a value unassigned. An unassigned path would infer a latch.
      w_is_mem_access   = ex_mem_read || ex_mem_write;
      w_addr_misaligned = 1'b0;
      w_rw_conflict     = 1'b0;
      w_branch_taken    = 1'b0;
      w_reg_write_gated = 1'b0;
      w_mem_read_gated  = 1'b0;
      w_mem_write_gated = 1'b0;

      // Only word accesses exist, so any nonzero low address bit is illegal.
      if (w_is_mem_access && (alu_out[1:0] != 2'b00)) begin
         w_addr_misaligned = 1'b1;
      end

      // A load and a store at the same time is a decoder fault. Neither access
      // is allowed to reach memory.
      if (ex_mem_read && ex_mem_write) begin
         w_rw_conflict = 1'b1;
      end

      // BEQ is taken on zero and BNE on nonzero. ex_branch_ne inverts the sense.
      if (ex_branch && (alu_zero ^ ex_branch_ne)) begin
         w_branch_taken = 1'b1;
      end

      // x0 is hardwired to zero and is never a writeback target. A misaligned
      // load would write garbage, so writeback is suppressed for it too.
      if (ex_reg_write && (ex_rd != '0) && !w_addr_misaligned) begin
         w_reg_write_gated = 1'b1;
      end

      if (!w_addr_misaligned && !w_rw_conflict) begin
         w_mem_read_gated  = ex_mem_read;
         w_mem_write_gated = ex_mem_write;
      end
   end

   // --------------------------------------------------------------------------
   // Valid bit and gated enables
   //
   // Priority is reset > flush > hold > capture/bubble. Flush empties the stage
   // even while MEM is stalling, because the held instruction is squashed too.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only. All
      // registers then update together from values sampled before the edge.
      if (rst) begin
         r_mem_valid     <= 1'b0;
         r_mem_reg_write <= 1'b0;
         r_mem_mem_read  <= 1'b0;
         r_mem_mem_write <= 1'b0;
      end else if (flush) begin
         r_mem_valid     <= 1'b0;
         r_mem_reg_write <= 1'b0;
         r_mem_mem_read  <= 1'b0;
         r_mem_mem_write <= 1'b0;
      end else if (w_ex_ready) begin
         // Capture or bubble. A bubble must clear every enable, so that
         // leftover data in the datapath registers has no effect downstream.
         r_mem_valid     <= ex_valid;
         r_mem_reg_write <= ex_valid && w_reg_write_gated;
         r_mem_mem_read  <= ex_valid && w_mem_read_gated;
         r_mem_mem_write <= ex_valid && w_mem_write_gated;
      end
      // else: hold, because MEM is stalled on a valid instruction
   end

   // --------------------------------------------------------------------------
   // Datapath registers
   //
   // These load only on capture. Bubbles and flushes leave them stale, which
   // is harmless because the enables above are cleared.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: the data registers are reset as well. After reset every output
      // then reads as a defined zero, not as leftover power-up contents.
      if (rst) begin
         r_mem_alu_out    <= '0;
         r_mem_rd         <= '0;
         r_mem_store_data <= '0;
      end else if (w_capture) begin
         r_mem_alu_out    <= alu_out;
         r_mem_rd         <= ex_rd;
         r_mem_store_data <= ex_store_data;
      end
   end

   // --------------------------------------------------------------------------
   // Single-cycle pulses: redirect and misaligned
   //
   // These fire only on the capture edge. A held instruction therefore never
   // re-fires them, and a flushed one never fires them at all.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_redirect_valid <= 1'b0;
         r_misaligned     <= 1'b0;
      end else begin
         r_redirect_valid <= w_capture && w_branch_taken;
         r_misaligned     <= w_capture && w_addr_misaligned;
      end
   end

   // The redirect target keeps its last value between pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_redirect_pc <= '0;
      end else if (w_capture && w_branch_taken) begin
         r_redirect_pc <= ex_branch_target;
      end
   end

   // Sticky decoder-fault flag. Only reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ctrl_err <= 1'b0;
      end else if (w_capture && w_rw_conflict) begin
         r_ctrl_err <= 1'b1;
      end
   end

`ifdef EX_MEM_BRANCH_STATS_EN
   // --------------------------------------------------------------------------
   // Branch statistics. Both counters wrap naturally modulo 2^32.
   // --------------------------------------------------------------------------
   logic [31:0] r_br_total;
   logic [31:0] r_br_taken;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_br_total <= '0;
         r_br_taken <= '0;
      end else if (w_capture && ex_branch) begin
         r_br_total <= r_br_total + 32'd1;
         if (w_branch_taken) begin
            r_br_taken <= r_br_taken + 32'd1;
         end
      end
   end

   assign br_total = r_br_total;
   assign br_taken = r_br_taken;
`endif

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign ex_ready       = w_ex_ready;
   assign mem_valid      = r_mem_valid;
   assign mem_alu_out    = r_mem_alu_out;
   assign mem_rd         = r_mem_rd;
   assign mem_reg_write  = r_mem_reg_write;
   assign mem_mem_read   = r_mem_mem_read;
   assign mem_mem_write  = r_mem_mem_write;
   assign mem_store_data = r_mem_store_data;
   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;
   assign misaligned     = r_misaligned;
   assign ctrl_err       = r_ctrl_err;

endmodule

// File: tb/tb_ex_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_mem_stage
//
// Testbench for ex_mem_stage. It applies directed scenarios followed by
// randomized traffic. Each step is compared against a transaction-level
// reference model of the EX/MEM register. Every comparison is an immediate
// assertion. The bench ends with one summary line.
// -----------------------------------------------------------------------------
module tb_ex_mem_stage;

   localparam int SIZE = 32;
   localparam int RDW  = 5;

   logic            clk;
   logic            rst;
   logic            flush;
   logic            ex_valid;
   logic            ex_ready;
   logic [SIZE-1:0] alu_out;
   logic            alu_zero;
   logic [RDW-1:0]  ex_rd;
   logic            ex_reg_write;
   logic            ex_mem_read;
   logic            ex_mem_write;
   logic [SIZE-1:0] ex_store_data;
   logic            ex_branch;
   logic            ex_branch_ne;
   logic [SIZE-1:0] ex_branch_target;
   logic            mem_stall;
   logic            mem_valid;
   logic [SIZE-1:0] mem_alu_out;
   logic [RDW-1:0]  mem_rd;
   logic            mem_reg_write;
   logic            mem_mem_read;
   logic            mem_mem_write;
   logic [SIZE-1:0] mem_store_data;
   logic            redirect_valid;
   logic [SIZE-1:0] redirect_pc;
   logic            misaligned;
   logic            ctrl_err;
`ifdef EX_MEM_BRANCH_STATS_EN
   logic [31:0]     br_total;
   logic [31:0]     br_taken;
`endif

   ex_mem_stage #(.size(SIZE), .RD_W(RDW)) dut (
      .clk              (clk),
      .rst              (rst),
      .flush            (flush),
      .ex_valid         (ex_valid),
      .ex_ready         (ex_ready),
      .alu_out          (alu_out),
      .alu_zero         (alu_zero),
      .ex_rd            (ex_rd),
      .ex_reg_write     (ex_reg_write),
      .ex_mem_read      (ex_mem_read),
      .ex_mem_write     (ex_mem_write),
      .ex_store_data    (ex_store_data),
      .ex_branch        (ex_branch),
      .ex_branch_ne     (ex_branch_ne),
      .ex_branch_target (ex_branch_target),
      .mem_stall        (mem_stall),
      .mem_valid        (mem_valid),
      .mem_alu_out      (mem_alu_out),
      .mem_rd           (mem_rd),
      .mem_reg_write    (mem_reg_write),
      .mem_mem_read     (mem_mem_read),
      .mem_mem_write    (mem_mem_write),
      .mem_store_data   (mem_store_data),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .misaligned       (misaligned),
      .ctrl_err         (ctrl_err)
`ifdef EX_MEM_BRANCH_STATS_EN
      ,
      .br_total         (br_total),
      .br_taken         (br_taken)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   // Expected contents of the MEM stage, described per transaction.
   typedef struct {
      logic        valid;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
      logic [31:0] sd;
      logic        redir_v;
      logic [31:0] redir_pc;
      logic        mis;
      logic        err;
      logic [31:0] br_tot;
      logic [31:0] br_tk;
   } model_t;

   model_t m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advances the reference model by one clock edge, using the inputs now applied.
   task automatic model_update();
      bit can_take;
      bit is_mem;
      bit bad_addr;
      bit both;
      bit taken;
      if (rst) begin
         m = '{default: '0};
      end else begin
         can_take = !m.valid || !mem_stall;
         m.redir_v = 1'b0;
         m.mis     = 1'b0;
         if (flush) begin
            // The offered instruction and the held one both vanish.
            m.valid = 1'b0; m.rw = 1'b0; m.mr = 1'b0; m.mw = 1'b0;
         end else if (can_take && !ex_valid) begin
            m.valid = 1'b0; m.rw = 1'b0; m.mr = 1'b0; m.mw = 1'b0;
         end else if (can_take) begin
            is_mem   = ex_mem_read || ex_mem_write;
            bad_addr = is_mem && ((alu_out % 4) != 0);
            both     = ex_mem_read && ex_mem_write;
            if (!ex_branch)        taken = 1'b0;
            else if (ex_branch_ne) taken = (alu_zero == 1'b0);
            else                   taken = (alu_zero == 1'b1);
            m.valid = 1'b1;
            m.alu   = alu_out;
            m.rd    = ex_rd;
            m.sd    = ex_store_data;
            m.rw    = ex_reg_write && (ex_rd != 0) && !bad_addr;
            m.mr    = ex_mem_read  && !bad_addr && !both;
            m.mw    = ex_mem_write && !bad_addr && !both;
            m.mis   = bad_addr;
            if (both) m.err = 1'b1;
            if (taken) begin
               m.redir_v  = 1'b1;
               m.redir_pc = ex_branch_target;
            end
            if (ex_branch) m.br_tot = m.br_tot + 1;
            if (taken)     m.br_tk  = m.br_tk + 1;
         end
      end
   endtask

   task automatic check_all();
      check("mem_valid",      32'(mem_valid),      32'(m.valid));
      check("mem_reg_write",  32'(mem_reg_write),  32'(m.rw));
      check("mem_mem_read",   32'(mem_mem_read),   32'(m.mr));
      check("mem_mem_write",  32'(mem_mem_write),  32'(m.mw));
      check("redirect_valid", 32'(redirect_valid), 32'(m.redir_v));
      check("redirect_pc",    redirect_pc,         m.redir_pc);
      check("misaligned",     32'(misaligned),     32'(m.mis));
      check("ctrl_err",       32'(ctrl_err),       32'(m.err));
      if (m.valid) begin
         check("mem_alu_out",    mem_alu_out,    m.alu);
         check("mem_rd",         32'(mem_rd),    32'(m.rd));
         check("mem_store_data", mem_store_data, m.sd);
      end
`ifdef EX_MEM_BRANCH_STATS_EN
      check("br_total", br_total, m.br_tot);
      check("br_taken", br_taken, m.br_tk);
`endif
   endtask

   // One clock: check the combinational ready, clock, update the model, compare.
   task automatic step();
      #1;
      if (!rst) check("ex_ready", 32'(ex_ready), 32'(!m.valid || !mem_stall));
      @(posedge clk);
      model_update();
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      rst = 1'b0; flush = 1'b0; ex_valid = 1'b0; mem_stall = 1'b0;
      alu_out = '0; alu_zero = 1'b0; ex_rd = '0; ex_reg_write = 1'b0;
      ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_store_data = '0;
      ex_branch = 1'b0; ex_branch_ne = 1'b0; ex_branch_target = '0;
   endtask

   initial begin
      m = '{default: '0};
      idle_inputs();

      // Reset: every output is zero, data outputs included.
      rst = 1'b1;
      step();
      step();
      check("rst mem_alu_out",    mem_alu_out,    32'h0);
      check("rst mem_rd",         32'(mem_rd),    32'h0);
      check("rst mem_store_data", mem_store_data, 32'h0);

      // Plain ALU instruction, one-cycle latency.
      idle_inputs();
      ex_valid = 1'b1; alu_out = 32'h10; ex_rd = 5'd5; ex_reg_write = 1'b1;
      step();
      check("cap mem_valid",     32'(mem_valid),     32'h1);
      check("cap mem_alu_out",   mem_alu_out,        32'h10);
      check("cap mem_rd",        32'(mem_rd),        32'h5);
      check("cap mem_reg_write", 32'(mem_reg_write), 32'h1);

      // BEQ taken.
      idle_inputs();
      ex_valid = 1'b1; ex_branch = 1'b1; alu_zero = 1'b1; ex_branch_target = 32'h200;
      step();
      check("beq redirect_valid", 32'(redirect_valid), 32'h1);
      check("beq redirect_pc",    redirect_pc,         32'h200);
      idle_inputs();
      step();
      check("beq pulse ends", 32'(redirect_valid), 32'h0);

      // BEQ not taken: the previous target is kept.
      ex_valid = 1'b1; ex_branch = 1'b1; alu_zero = 1'b0; ex_branch_target = 32'h300;
      step();
      check("beq nt redirect_valid", 32'(redirect_valid), 32'h0);
      check("beq nt redirect_pc",    redirect_pc,         32'h200);

      // BNE taken.
      idle_inputs();
      ex_valid = 1'b1; ex_branch = 1'b1; ex_branch_ne = 1'b1; alu_zero = 1'b0;
      ex_branch_target = 32'h400;
      step();
      check("bne redirect_valid", 32'(redirect_valid), 32'h1);
      check("bne redirect_pc",    redirect_pc,         32'h400);

      // A taken branch stalled in the stage does not pulse again.
      idle_inputs();
      ex_valid = 1'b1; ex_branch = 1'b1; alu_zero = 1'b1; ex_branch_target = 32'h500;
      step();
      mem_stall = 1'b1; ex_branch = 1'b0;
      step();
      check("held no re-pulse", 32'(redirect_valid), 32'h0);
      check("held valid",       32'(mem_valid),      32'h1);

      // Stall for three cycles with the next instruction waiting.
      idle_inputs();
      ex_valid = 1'b1; alu_out = 32'h20; ex_rd = 5'd6; ex_reg_write = 1'b1;
      step();
      mem_stall = 1'b1; alu_out = 32'h30; ex_rd = 5'd7;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall ex_ready", 32'(ex_ready), 32'h0);
         step();
         check("stall hold alu", mem_alu_out, 32'h20);
         check("stall hold rd",  32'(mem_rd), 32'h6);
      end
      mem_stall = 1'b0;
      step();
      check("release alu", mem_alu_out, 32'h30);
      check("release rd",  32'(mem_rd), 32'h7);

      // Misaligned load.
      idle_inputs();
      ex_valid = 1'b1; ex_mem_read = 1'b1; alu_out = 32'h102; ex_rd = 5'd8; ex_reg_write = 1'b1;
      step();
      check("mis pulse",     32'(misaligned),    32'h1);
      check("mis mem_read",  32'(mem_mem_read),  32'h0);
      check("mis reg_write", 32'(mem_reg_write), 32'h0);
      check("mis valid",     32'(mem_valid),     32'h1);

      // Aligned store.
      idle_inputs();
      ex_valid = 1'b1; ex_mem_write = 1'b1; alu_out = 32'h104; ex_store_data = 32'hCAFE_F00D;
      step();
      check("st mem_write",  32'(mem_mem_write), 32'h1);
      check("st store_data", mem_store_data,     32'hCAFE_F00D);
      check("st no mis",     32'(misaligned),    32'h0);

      // Flush together with a taken branch.
      idle_inputs();
      ex_valid = 1'b1; flush = 1'b1; ex_branch = 1'b1; alu_zero = 1'b1; ex_branch_target = 32'h600;
      step();
      check("flush valid",    32'(mem_valid),      32'h0);
      check("flush redirect", 32'(redirect_valid), 32'h0);

      // Writeback to x0 is suppressed.
      idle_inputs();
      ex_valid = 1'b1; ex_rd = 5'd0; ex_reg_write = 1'b1; alu_out = 32'h44;
      step();
      check("x0 reg_write", 32'(mem_reg_write), 32'h0);
      check("x0 valid",     32'(mem_valid),     32'h1);

      // Load and store together: sticky ctrl_err.
      idle_inputs();
      ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b1; alu_out = 32'h80;
      step();
      check("err set",   32'(ctrl_err),      32'h1);
      check("err no rd", 32'(mem_mem_read),  32'h0);
      check("err no wr", 32'(mem_mem_write), 32'h0);
      idle_inputs();
      for (int i = 0; i < 4; i++) step();
      check("err sticky", 32'(ctrl_err), 32'h1);
      rst = 1'b1;
      step();
      check("err cleared", 32'(ctrl_err), 32'h0);

      // Stall with an empty stage still accepts.
      idle_inputs();
      mem_stall = 1'b1; ex_valid = 1'b1; alu_out = 32'h90; ex_rd = 5'd3;
      #1;
      check("empty stall ready", 32'(ex_ready), 32'h1);
      step();
      check("empty stall cap", 32'(mem_valid), 32'h1);

`ifdef EX_MEM_BRANCH_STATS_EN
      // Four branches, three of them taken.
      idle_inputs();
      rst = 1'b1;
      step();
      idle_inputs();
      ex_valid = 1'b1; ex_branch = 1'b1;
      alu_zero = 1'b1; ex_branch_ne = 1'b0; step();
      alu_zero = 1'b0; ex_branch_ne = 1'b1; step();
      alu_zero = 1'b0; ex_branch_ne = 1'b0; step();
      alu_zero = 1'b1; ex_branch_ne = 1'b0; step();
      check("stats total", br_total, 32'd4);
      check("stats taken", br_taken, 32'd3);
`endif

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         rst              = ($urandom_range(63) == 0);
         flush            = ($urandom_range(7) == 0);
         mem_stall        = ($urandom_range(2) == 0);
         ex_valid         = ($urandom_range(3) != 0);
         alu_out          = $urandom;
         if ($urandom_range(1) == 0) alu_out[1:0] = 2'b00;
         alu_zero         = 1'($urandom_range(1));
         ex_rd            = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
         ex_reg_write     = 1'($urandom_range(1));
         ex_mem_read      = ($urandom_range(2) == 0);
         ex_mem_write     = ($urandom_range(2) == 0);
         ex_store_data    = $urandom;
         ex_branch        = ($urandom_range(2) == 0);
         ex_branch_ne     = 1'($urandom_range(1));
         ex_branch_target = $urandom;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
